ace_snoop_scheduler: RTL
========================

Name: ace_snoop_scheduler

Overview:
- Shares the single ACE snoop port of std_nbdcache (AC request, CR response, CD data) between NrSources snoop initiators, e.g. the CCU and a coherence test driver.
- Grants one source at a time, round-robin, and forwards its AC request to the cache.
- Routes the cache's CR response and CD data beats back to the granted source only.
- Holds exactly one snoop transaction in flight.

Parameters:
- NrSources, 2, number of snoop initiators (>=2).
- AddrWidth, 64, AC address width.
- DataWidth, 64, CD data width.
- TimeoutCycles, 1024, cycle limit per transaction before timeout_o is set (>=2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset (see Behaviour)
- src_ac_valid_i  in  NrSources  per-source snoop request valid
- src_ac_ready_o  out  NrSources  per-source request accept
- src_ac_addr_i  in  NrSources*AddrWidth  per-source AC address
- src_ac_snoop_i  in  NrSources*4  per-source AC snoop type
- src_ac_prot_i  in  NrSources*3  per-source AC prot
- ac_valid_o  out  1  request valid to cache
- ac_ready_i  in  1  cache accepts request
- ac_addr_o  out  AddrWidth  latched address
- ac_snoop_o  out  4  latched snoop type
- ac_prot_o  out  3  latched prot
- cr_valid_i  in  1  cache CR valid
- cr_ready_o  out  1  CR ready to cache
- cr_resp_i  in  5  CR resp; bit0 = DataTransfer
- src_cr_valid_o  out  NrSources  CR valid to owner
- src_cr_ready_i  in  NrSources  per-source CR ready
- src_cr_resp_o  out  5  CR resp, broadcast to all sources
- cd_valid_i  in  1  cache CD valid
- cd_ready_o  out  1  CD ready to cache
- cd_data_i  in  DataWidth  CD data
- cd_last_i  in  1  CD last beat
- src_cd_valid_o  out  NrSources  CD valid to owner
- src_cd_ready_i  in  NrSources  per-source CD ready
- src_cd_data_o  out  DataWidth  CD data, broadcast
- src_cd_last_o  out  1  CD last, broadcast
- owner_o  out  $clog2(NrSources)  current grant index
- busy_o  out  1  transaction in flight
- timeout_o  out  1  sticky timeout flag
- proto_err_o  out  1  sticky protocol-error flag

Behaviour:
- Clock clk_i, rising edge. Reset rst_ni, asynchronous, active-high.
- All outputs reset to 0. State resets to IDLE, round-robin pointer to 0, flags cleared.
- Reset asserted mid-transaction drops the transaction; no response is forwarded afterwards.
- States: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - Pick the first requesting source at or after the pointer, wrapping modulo NrSources.
  - Pulse src_ac_ready_o[g] for one cycle; latch addr/snoop/prot and owner g.
  - Set pointer to (g+1) mod NrSources; go to ISSUE.
  - No requests: stay in IDLE.
- ISSUE:
  - ac_valid_o=1 with latched fields held stable until ac_ready_i.
  - Latency: src handshake at cycle N gives ac_valid_o at N+1.
  - On ac_ready_i, go to WAIT_RESP.
- WAIT_RESP, CR path (combinational):
  - src_cr_valid_o[owner]=cr_valid_i; cr_ready_o=src_cr_ready_i[owner]; all other src_cr_valid_o=0.
  - On the CR handshake, set cr_done and record need_cd=cr_resp_i[0].
- WAIT_RESP, CD path (combinational):
  - src_cd_valid_o[owner]=cd_valid_i; cd_ready_o=src_cd_ready_i[owner].
  - CD beats may arrive before, with, or after CR. A handshake with cd_last_i sets cd_done.
- Completion:
  - Done when cr_done && (!need_cd || cd_done); return to IDLE next cycle.
  - CR and the last CD beat in the same cycle complete in that cycle.
- Protocol errors (set proto_err_o):
  - any CD beat after a CR with resp[0]=0;
  - CD completed but CR arrives with resp[0]=0;
  - cr_valid_i or cd_valid_i high in IDLE or ISSUE.
  - In IDLE/ISSUE those beats are not accepted (ready=0).
- busy_o=1 in ISSUE and WAIT_RESP.
- Timeout:
  - A 16-bit counter clears on entering ISSUE and increments every cycle in ISSUE/WAIT_RESP.
  - When it reaches TimeoutCycles-1, timeout_o is set (sticky) and the FSM is forced to IDLE, abandoning the transaction.
- While not in IDLE, all src_ac_ready_o=0 regardless of requests.

Test Plan:
- Single source 0 requests addr 0x1000, snoop 4'b0001; cache ready at once, CR resp 5'b00000 → ac_valid_o high one cycle after accept; src_cr_valid_o=2'b01; busy_o back to 0 two cycles after CR.
- Sources 0 and 1 request continuously, 4 transactions → grant order 0,1,0,1; owner_o matches each; src_cr_valid_o never asserted to the non-owner.
- CR resp=5'b00001 with 4 CD beats, and src_cd_ready_i[1] toggling → all 4 beats delivered to source 1 in order; IDLE only after the beat with cd_last_i=1.
- CD's 2 beats arrive before CR resp=1, then the CR and last beat coincide in one cycle → completes; proto_err_o=0.
- CR resp=0 followed by a cd_valid_i beat → proto_err_o=1 and stays set.
- TimeoutCycles=16, ac_ready_i held 0 → timeout_o=1 at cycle 15 after entering ISSUE, FSM back in IDLE. Asserting rst_ni mid-WAIT_RESP then clears all outputs immediately.

Source files
------------

// File: rtl/ace_snoop_scheduler.sv
// Arbitrates NrSources snoop initiators onto one ACE snoop port (AC/CR/CD).
// One transaction in flight: round-robin grant in IDLE, AC issue in ISSUE,
// CR/CD steered to the owner in WAIT_RESP.
// Ports:
//   src_ac_*          per-source AC request (ready pulses for one cycle on grant)
//   ac_*              latched AC request towards the cache
//   cr_* / src_cr_*   CR response, routed to the owner (resp broadcast)
//   cd_* / src_cd_*   CD data beats, routed to the owner (data/last broadcast)
//   owner_o, busy_o   current grant index and in-flight indication
//   timeout_o, proto_err_o  sticky status flags
module ace_snoop_scheduler #(
  parameter int unsigned NrSources     = 2,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NrSources-1:0]            src_ac_valid_i,
  output logic [NrSources-1:0]            src_ac_ready_o,
  input  logic [NrSources*AddrWidth-1:0]  src_ac_addr_i,
  input  logic [NrSources*4-1:0]          src_ac_snoop_i,
  input  logic [NrSources*3-1:0]          src_ac_prot_i,
  output logic                            ac_valid_o,
  input  logic                            ac_ready_i,
  output logic [AddrWidth-1:0]            ac_addr_o,
  output logic [3:0]                      ac_snoop_o,
  output logic [2:0]                      ac_prot_o,
  input  logic                            cr_valid_i,
  output logic                            cr_ready_o,
  input  logic [4:0]                      cr_resp_i,
  output logic [NrSources-1:0]            src_cr_valid_o,
  input  logic [NrSources-1:0]            src_cr_ready_i,
  output logic [4:0]                      src_cr_resp_o,
  input  logic                            cd_valid_i,
  output logic                            cd_ready_o,
  input  logic [DataWidth-1:0]            cd_data_i,
  input  logic                            cd_last_i,
  output logic [NrSources-1:0]            src_cd_valid_o,
  input  logic [NrSources-1:0]            src_cd_ready_i,
  output logic [DataWidth-1:0]            src_cd_data_o,
  output logic                            src_cd_last_o,
  output logic [$clog2(NrSources)-1:0]    owner_o,
  output logic                            busy_o,
  output logic                            timeout_o,
  output logic                            proto_err_o
);

  localparam int unsigned IdxW = $clog2(NrSources);
  localparam int unsigned CntW = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_e;

  state_e          r_state, w_state_next;
  logic [IdxW-1:0] r_owner, r_ptr, w_grant, w_idx;
  logic            w_found;
  logic [AddrWidth-1:0] r_addr;
  logic [3:0]      r_snoop;
  logic [2:0]      r_prot;
  logic [CntW-1:0] r_cnt;
  logic            r_cr_done, r_need_cd, r_cd_done, r_cd_seen;
  logic            r_timeout, r_proto_err;
  logic            w_busy, w_timeout_hit, w_done;
  logic            w_cr_open, w_cd_open, w_cr_hs, w_cd_hs, w_err;

  // Round-robin pick: first requester at or after the pointer, wrapping.
  always_comb begin : rr_pick
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NrSources; i++) begin
      w_idx = IdxW'((32'(r_ptr) + i) % NrSources);
      if (!w_found && src_ac_valid_i[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_busy        = (r_state != IDLE);
  // Firing one count early makes timeout_o rise as the counter lands on TimeoutCycles-1.
  assign w_timeout_hit = w_busy && (r_cnt == CntW'(TimeoutCycles - 2));
  assign w_done        = (r_state == WAIT_RESP) && r_cr_done && (!r_need_cd || r_cd_done);
  // Each channel closes once its part is done; CD also closes after a dataless CR.
  assign w_cr_open     = (r_state == WAIT_RESP) && !r_cr_done;
  assign w_cd_open     = (r_state == WAIT_RESP) && !r_cd_done && !(r_cr_done && !r_need_cd);

  // State register.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and combinational routing.
  always_comb begin
    w_state_next   = r_state;
    src_ac_ready_o = '0;
    src_cr_valid_o = '0;
    src_cd_valid_o = '0;
    cr_ready_o     = 1'b0;
    cd_ready_o     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          src_ac_ready_o[w_grant] = !rst_ni;
          w_state_next            = ISSUE;
        end
      end
      ISSUE: begin
        if (w_timeout_hit)   w_state_next = IDLE;
        else if (ac_ready_i) w_state_next = WAIT_RESP;
      end
      WAIT_RESP: begin
        src_cr_valid_o[r_owner] = cr_valid_i && w_cr_open;
        src_cd_valid_o[r_owner] = cd_valid_i && w_cd_open;
        cr_ready_o              = src_cr_ready_i[r_owner] && w_cr_open;
        cd_ready_o              = src_cd_ready_i[r_owner] && w_cd_open;
        if (w_timeout_hit || w_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_cr_hs = cr_valid_i && cr_ready_o;
  assign w_cd_hs = cd_valid_i && cd_ready_o;

  // Stray beats outside WAIT_RESP, data after a dataless CR, dataless CR after data.
  assign w_err = (!(r_state == WAIT_RESP) && (cr_valid_i || cd_valid_i))
              || ((r_state == WAIT_RESP) && r_cr_done && !r_need_cd && cd_valid_i)
              || (w_cr_hs && !cr_resp_i[0] && (r_cd_seen || w_cd_hs));

  // Request latch, transaction tracking and sticky flags.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      r_owner     <= '0;
      r_ptr       <= '0;
      r_addr      <= '0;
      r_snoop     <= '0;
      r_prot      <= '0;
      r_cnt       <= '0;
      r_cr_done   <= 1'b0;
      r_need_cd   <= 1'b0;
      r_cd_done   <= 1'b0;
      r_cd_seen   <= 1'b0;
      r_timeout   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (r_state == IDLE && w_found) begin
        r_owner   <= w_grant;
        r_ptr     <= IdxW'((32'(w_grant) + 1) % NrSources);
        r_addr    <= src_ac_addr_i[32'(w_grant)*AddrWidth +: AddrWidth];
        r_snoop   <= src_ac_snoop_i[32'(w_grant)*4 +: 4];
        r_prot    <= src_ac_prot_i[32'(w_grant)*3 +: 3];
        r_cnt     <= '0;
        r_cr_done <= 1'b0;
        r_need_cd <= 1'b0;
        r_cd_done <= 1'b0;
        r_cd_seen <= 1'b0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + CntW'(1);
      end
      if (w_cr_hs) begin
        r_cr_done <= 1'b1;
        r_need_cd <= cr_resp_i[0];
      end
      if (w_cd_hs) begin
        r_cd_seen <= 1'b1;
        if (cd_last_i) r_cd_done <= 1'b1;
      end
      if (w_timeout_hit) r_timeout   <= 1'b1;
      if (w_err)         r_proto_err <= 1'b1;
    end
  end

  assign ac_valid_o    = (r_state == ISSUE);
  assign ac_addr_o     = r_addr;
  assign ac_snoop_o    = r_snoop;
  assign ac_prot_o     = r_prot;
  assign owner_o       = r_owner;
  assign busy_o        = w_busy;
  assign timeout_o     = r_timeout;
  assign proto_err_o   = r_proto_err;
  // Broadcast payloads are only driven while a response can be in flight.
  assign src_cr_resp_o = (r_state == WAIT_RESP) ? cr_resp_i : 5'd0;
  assign src_cd_data_o = (r_state == WAIT_RESP) ? cd_data_i : '0;
  assign src_cd_last_o = (r_state == WAIT_RESP) && cd_last_i;

endmodule
